uart_rx_fifo_cfg: RTL and testbench
===================================

Name: uart_rx_fifo_cfg

Overview:
Parametrised UART receiver with an integrated receive FIFO, successor to the fixed 8N1 receiver-plus-FIFO top.
- Adds runtime parity (none/even/odd) and 1/2 stop bits; data width is set by parameter.
- Adds start-bit glitch rejection and per-word parity/framing error tags stored in the FIFO, plus a sticky overflow flag.
- Exposes a first-word-fall-through read port, so downstream image-processing logic can drain bytes directly.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9), LSB first
FIFO_DEPTH, 32, FIFO entries (power of two, >=2)
BAUD_W, 17, width of baud_div input

Ports:
clk_i_rxc  in  1  system clock
rst_i_rxc  in  1  asynchronous active-high reset
active_i_rxc  in  1  receiver enable; low forces FSM to IDLE
data_i_serial_rxc  in  1  serial line, idle high, asynchronous
baud_div_rxc  in  BAUD_W  clock cycles per bit (>=4)
parity_en_i_rxc  in  1  parity bit present
parity_odd_i_rxc  in  1  1=odd, 0=even parity
two_stop_i_rxc  in  1  1=two stop bits
rd_en_i_rxc  in  1  pop head word
clear_err_i_rxc  in  1  clears overflow_o_rxc
rd_data_o_rxc  out  DATA_WIDTH  head word data
rd_perr_o_rxc  out  1  head word parity error tag
rd_ferr_o_rxc  out  1  head word framing error tag
full_o_rxc  out  1  FIFO full
empty_o_rxc  out  1  FIFO empty
count_o_rxc  out  $clog2(FIFO_DEPTH+1)  words stored
overflow_o_rxc  out  1  sticky: frame dropped on full
busy_o_rxc  out  1  FSM not in IDLE

Behaviour:
- Reset values: FSM=IDLE, synchronizer=1, all pointers/count=0, empty=1, full=0, overflow=0, busy=0, rd_data/perr/ferr=0.
- Line passes a 2-FF synchronizer, so there are 2 cycles of latency. All timing below is on the synchronized line.
- The config inputs (parity_en, parity_odd, two_stop) are latched on the start-edge detect and held for the whole frame.
- IDLE: active=1 and a synchronized 1->0 transition -> START; baud_cnt=0.
- START: sample at baud_cnt = baud_div/2 - 1 (integer divide).
  - If the line is high, this is a glitch: return to IDLE, no push.
  - If the line is low: go to DATA, reset baud_cnt, bit_idx=0.
- DATA: sample every baud_div cycles into shift register, LSB first. After DATA_WIDTH samples -> PARITY if parity_en, else STOP.
- PARITY: one sample. perr = (XOR of data bits XOR sampled bit) != parity_odd.
- STOP: one or two samples per latched two_stop. Any stop sample low sets ferr. At the final stop sample the word is pushed with {perr, ferr, data}.
  - Push with ferr=1 -> WAIT_IDLE.
  - Push with ferr=0 -> IDLE.
- WAIT_IDLE: remain until the synchronized line is high, then IDLE. This prevents a break condition from spawning frames.
- active=0: in any state, next state is IDLE, the partial frame is discarded and no push occurs. FIFO contents and flags are kept; reads remain legal.
- FIFO:
  - Push succeeds if !full, or if full and rd_en with !empty in the same cycle (pop-then-push).
  - A push refused on full drops the word and sets overflow=1.
  - rd_en while empty is ignored; pointers are unchanged.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - First-word fall-through: after a push into an empty FIFO, empty drops and rd_data is valid on the next cycle. rd_data updates the cycle after a pop.
- overflow: cleared only by clear_err=1 (or reset). If set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame: immediate return to reset values; the frame is lost.

Test Plan:
- 8N1, baud_div=868, 10 ns clock, send 0xA5 -> within 2 cycles of the stop sample: empty=0, count=1, rd_data=0xA5, perr=0, ferr=0; pulse rd_en -> empty=1.
- Even parity enabled, send 0x3C with correct parity 0, then 0x3C with parity 1 -> two words: perr=0, then perr=1, both data=0x3C.
- Two stop bits, second stop held low, then line high for 1 bit, then send 0x11 -> word 1 ferr=1; FSM passes WAIT_IDLE; word 2 =0x11 with ferr=0.
- Low pulse of 300 cycles (< 434) on idle line -> no push, busy returns to 0, count stays 0.
- DEPTH=32, send 33 random bytes with no reads -> full=1 after 32nd; 33rd dropped, overflow=1; draining returns the first 32 in order; clear_err -> overflow=0.
- Drop active at bit 4 of a frame, then reassert and send 0x5A -> only 0x5A stored. Separately, assert rst mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_fifo_cfg.sv
// UART receiver with runtime parity / stop-bit configuration and an
// integrated first-word-fall-through receive FIFO. Each FIFO entry carries
// the received data plus parity-error and framing-error tags.
//
// Handshake: the read port is FWFT. When empty_o_rxc is low, the head word
// is already visible on rd_data_o_rxc/rd_perr_o_rxc/rd_ferr_o_rxc, and
// rd_en_i_rxc pops it on the next clock edge. rd_en_i_rxc while empty is
// ignored. The receive side has no backpressure: a frame that completes
// while the FIFO is full (and not being popped in the same cycle) is dropped
// and raises the sticky overflow flag.
module uart_rx_fifo_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int BAUD_W     = 17
) (
  input  logic                            clk_i_rxc,
  input  logic                            rst_i_rxc,
  input  logic                            active_i_rxc,
  input  logic                            data_i_serial_rxc,
  input  logic [BAUD_W-1:0]               baud_div_rxc,
  input  logic                            parity_en_i_rxc,
  input  logic                            parity_odd_i_rxc,
  input  logic                            two_stop_i_rxc,
  input  logic                            rd_en_i_rxc,
  input  logic                            clear_err_i_rxc,
  output logic [DATA_WIDTH-1:0]           rd_data_o_rxc,
  output logic                            rd_perr_o_rxc,
  output logic                            rd_ferr_o_rxc,
  output logic                            full_o_rxc,
  output logic                            empty_o_rxc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o_rxc,
  output logic                            overflow_o_rxc,
  output logic                            busy_o_rxc,
  output logic [2:0]                      state_dbg_rxc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int WW = DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t state, state_next;

  logic                  sync1, sync2, sync_prev;
  logic                  line, fall;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BAUD_W-1:0]     half_m1, bit_m1;
  logic                  mid_start, tick;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  cfg_par_en, cfg_par_odd, cfg_two_stop;
  logic                  perr_r, ferr_r, stop_idx;
  logic                  ferr_now, stop_last;
  logic                  push;
  logic [WW-1:0]         push_word;

  logic [WW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop, push_ok;
  logic [WW-1:0]         head;

  assign line      = sync2;
  assign fall      = sync_prev & ~sync2;
  assign half_m1   = (baud_div_rxc >> 1) - BAUD_W'(1);
  assign bit_m1    = baud_div_rxc - BAUD_W'(1);
  assign mid_start = (baud_cnt == half_m1);
  assign tick      = (baud_cnt == bit_m1);
  assign ferr_now  = ferr_r | ~line;
  assign stop_last = (stop_idx == cfg_two_stop);
  assign push_word = {perr_r, ferr_now, shift};

  // Two-flop synchronizer on the asynchronous serial line, plus edge history.
  always_ff @(posedge clk_i_rxc or posedge rst_i_rxc) begin
    if (rst_i_rxc) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= data_i_serial_rxc;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i_rxc or posedge rst_i_rxc) begin
    if (rst_i_rxc) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state and push decode; deasserting active aborts any frame silently.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      S_IDLE:      if (fall) state_next = S_START;
      S_START:     if (mid_start) state_next = line ? S_IDLE : S_DATA;
      S_DATA:      if (tick && bit_idx == IW'(DATA_WIDTH-1))
                     state_next = cfg_par_en ? S_PARITY : S_STOP;
      S_PARITY:    if (tick) state_next = S_STOP;
      S_STOP:      if (tick && stop_last) begin
                     push       = 1'b1;
                     state_next = ferr_now ? S_WAIT_IDLE : S_IDLE;
                   end
      S_WAIT_IDLE: if (line) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (!active_i_rxc) begin
      state_next = S_IDLE;
      push       = 1'b0;
    end
  end

  // Receive datapath: bit timing, shift register, latched config, error tags.
  always_ff @(posedge clk_i_rxc or posedge rst_i_rxc) begin
    if (rst_i_rxc) begin
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      cfg_par_en   <= 1'b0;
      cfg_par_odd  <= 1'b0;
      cfg_two_stop <= 1'b0;
      perr_r       <= 1'b0;
      ferr_r       <= 1'b0;
      stop_idx     <= 1'b0;
    end else begin
      if (state == S_IDLE || state_next != state || tick) baud_cnt <= '0;
      else                                                baud_cnt <= baud_cnt + BAUD_W'(1);

      if (state == S_IDLE && fall && active_i_rxc) begin
        cfg_par_en   <= parity_en_i_rxc;
        cfg_par_odd  <= parity_odd_i_rxc;
        cfg_two_stop <= two_stop_i_rxc;
        perr_r       <= 1'b0;
        ferr_r       <= 1'b0;
        stop_idx     <= 1'b0;
        bit_idx      <= '0;
      end

      if (state == S_DATA && tick) begin
        shift   <= {line, shift[DATA_WIDTH-1:1]};
        bit_idx <= bit_idx + IW'(1);
      end

      if (state == S_PARITY && tick)
        perr_r <= ((^shift) ^ line) != cfg_par_odd;

      if (state == S_STOP && tick) begin
        ferr_r   <= ferr_now;
        stop_idx <= 1'b1;
      end
    end
  end

  // FIFO bookkeeping: pop-then-push allowed when full, refused pushes flag overflow.
  assign pop     = rd_en_i_rxc & (count != '0);
  assign push_ok = push & ((count != CW'(FIFO_DEPTH)) | pop);

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i_rxc or posedge rst_i_rxc) begin
    if (rst_i_rxc) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow_o_rxc <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok)  overflow_o_rxc <= 1'b1;
      else if (clear_err_i_rxc) overflow_o_rxc <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign rd_data_o_rxc = head[DATA_WIDTH-1:0];
  assign rd_ferr_o_rxc = head[DATA_WIDTH];
  assign rd_perr_o_rxc = head[DATA_WIDTH+1];
  assign count_o_rxc   = count;
  assign empty_o_rxc   = (count == '0);
  assign full_o_rxc    = (count == CW'(FIFO_DEPTH));
  assign busy_o_rxc    = (state != S_IDLE);
  assign state_dbg_rxc = state;

endmodule

// File: tb/tb_uart_rx_fifo_cfg.sv
// Directed bench for uart_rx_fifo_cfg: serial frames are driven bit by bit,
// the expected {perr, ferr, data} words are queued as they are sent, and
// popped from the FWFT read port for comparison.
module tb_uart_rx_fifo_cfg;

  logic        clk;
  logic        rst;
  logic        active;
  logic        line;
  logic [16:0] baud_div;
  logic        parity_en, parity_odd, two_stop;
  logic        rd_en, clear_err;
  logic [7:0]  rd_data;
  logic        rd_perr, rd_ferr;
  logic        full, empty;
  logic [5:0]  count;
  logic        overflow, busy;
  logic [2:0]  state_dbg;

  int bd;
  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];

  uart_rx_fifo_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .BAUD_W(17)) dut (
    .clk_i_rxc        (clk),
    .rst_i_rxc        (rst),
    .active_i_rxc     (active),
    .data_i_serial_rxc(line),
    .baud_div_rxc     (baud_div),
    .parity_en_i_rxc  (parity_en),
    .parity_odd_i_rxc (parity_odd),
    .two_stop_i_rxc   (two_stop),
    .rd_en_i_rxc      (rd_en),
    .clear_err_i_rxc  (clear_err),
    .rd_data_o_rxc    (rd_data),
    .rd_perr_o_rxc    (rd_perr),
    .rd_ferr_o_rxc    (rd_ferr),
    .full_o_rxc       (full),
    .empty_o_rxc      (empty),
    .count_o_rxc      (count),
    .overflow_o_rxc   (overflow),
    .busy_o_rxc       (busy),
    .state_dbg_rxc    (state_dbg)
  );

  // Clock and baud divisor.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_comb baud_div = bd[16:0];

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (bd) @(negedge clk);
  endtask

  // Drives one frame in the current format. The final stop bit is held only
  // long enough for the receiver to sample it and push (plus two cycles).
  task automatic send_frame(input logic [7:0] d, input bit par_flip,
                            input bit stop_low, input bit expect_push);
    if (expect_push) exp_q.push_back({parity_en & par_flip, stop_low, d});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (parity_en) drive_bit((^d) ^ parity_odd ^ par_flip);
    if (two_stop) drive_bit(1'b1);
    line = ~stop_low;
    repeat (bd/2 + 5) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] exp;
    int n;
    n = 0;
    while (empty && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_avail"}, {31'd0, empty}, 32'd0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_queue: observed empty expected pending word", tag);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp[7:0]});
      check({tag, "_ferr"}, {31'd0, rd_ferr}, {31'd0, exp[8]});
      check({tag, "_perr"}, {31'd0, rd_perr}, {31'd0, exp[9]});
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; active = 1'b1; line = 1'b1; bd = 868;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    rd_en = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {26'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 at 868 cycles/bit.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_empty", {31'd0, empty}, 32'd0);
    check("a5_count", {26'd0, count}, 32'd1);
    pop_check("a5");
    check("a5_drained", {31'd0, empty}, 32'd1);

    // Short low glitch is rejected at mid-start.
    line = 1'b0;
    repeat (150) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    repeat (150) @(negedge clk);
    line = 1'b1;
    repeat (500) @(negedge clk);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_count", {26'd0, count}, 32'd0);

    // Faster baud for the remaining frames.
    bd = 16;
    repeat (4) @(negedge clk);

    // Even parity good then bad, then odd parity good.
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b0, 1'b0, 1'b1);
    pop_check("par_good");
    pop_check("par_bad");
    pop_check("par_odd");

    // Two stop bits, second held low: framing error then wait for idle.
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
    send_frame(8'h96, 1'b0, 1'b1, 1'b1);
    check("ferr_wait_idle", {29'd0, state_dbg}, 32'd5);
    line = 1'b1;
    repeat (bd) @(negedge clk);
    check("ferr_back_idle", {29'd0, state_dbg}, 32'd0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    pop_check("ferr_word");
    pop_check("after_ferr");
    two_stop = 1'b0;

    // Fill past depth with no reads.
    for (int i = 0; i < 33; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b0, 1'b0, i < 32);
      if (i == 31) begin
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", {26'd0, count}, 32'd32);
        check("fill_no_ovf", {31'd0, overflow}, 32'd0);
      end
    end
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {26'd0, count}, 32'd32);
    for (int i = 0; i < 32; i++) pop_check("drain");
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pop_empty_count", {26'd0, count}, 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("ovf_clear", {31'd0, overflow}, 32'd0);

    // Drop active mid-frame, then a clean frame.
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    active = 1'b0;
    @(negedge clk);
    check("inactive_busy", {31'd0, busy}, 32'd0);
    line = 1'b1;
    repeat (bd * 8) @(negedge clk);
    check("inactive_count", {26'd0, count}, 32'd0);
    active = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("reactive_count", {26'd0, count}, 32'd1);
    pop_check("reactive");
    check("reactive_empty", {31'd0, empty}, 32'd1);

    // Reset mid-frame with a word stored.
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", {26'd0, count}, 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_count", {26'd0, count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {24'd0, rd_data}, 32'd0);
    check("mid_rst_tags", {30'd0, rd_perr, rd_ferr}, 32'd0);
    check("mid_rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    repeat (bd * 12) @(negedge clk);
    check("post_rst_count", {26'd0, count}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
